// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback-stage register file.
package wb_regfile_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_regfile_mux.sv
// 2:1 writeback select between load data and ALU result.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_alu,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = i_sel ? i_mem : i_alu;
endmodule

// File: rtl/wb_regfile.sv
// Flop-based register file with WB-stage write, same-cycle bypass to ID reads,
// and a free-running count of committed writes.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = wb_regfile_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemtoReg_WB,
  input  logic                  RegWrite_WB,
  input  logic [DATA_W-1:0]     dmReadData_WB,
  input  logic [DATA_W-1:0]     ALUResult_WB,
  input  logic [REG_ADDR_W-1:0] Dst_WB,
  input  logic [REG_ADDR_W-1:0] rs_ID,
  input  logic [REG_ADDR_W-1:0] rt_ID,
  output logic [DATA_W-1:0]     rsData_ID,
  output logic [DATA_W-1:0]     rtData_ID,
  output logic [DATA_W-1:0]     WriteData_WB,
  output logic [31:0]           RetireCount
);
  logic [NREG-1:0][DATA_W-1:0] r_regs;
  logic [31:0]                 r_retire;
  logic [DATA_W-1:0]           w_wdata;
  logic                        w_commit;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .i_sel  (MemtoReg_WB),
    .i_mem  (dmReadData_WB),
    .i_alu  (ALUResult_WB),
    .o_data (w_wdata)
  );

  // Register 0 is hardwired: a write to it is not a commit and is not counted.
  assign w_commit = RegWrite_WB && (Dst_WB != ZERO_REG) && (int'(Dst_WB) < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs   <= '0;
      r_retire <= '0;
    end else if (w_commit) begin
      r_regs[Dst_WB] <= w_wdata;
      r_retire       <= r_retire + 32'd1;
    end
  end

  // Bypass hides the one-cycle write latency from the ID stage.
  always_comb begin
    rsData_ID = '0;
    if (w_commit && (rs_ID == Dst_WB))
      rsData_ID = w_wdata;
    else if ((rs_ID != ZERO_REG) && (int'(rs_ID) < NREG))
      rsData_ID = r_regs[rs_ID];
  end

  always_comb begin
    rtData_ID = '0;
    if (w_commit && (rt_ID == Dst_WB))
      rtData_ID = w_wdata;
    else if ((rt_ID != ZERO_REG) && (int'(rt_ID) < NREG))
      rtData_ID = r_regs[rt_ID];
  end

  assign WriteData_WB = w_wdata;
  assign RetireCount  = r_retire;
endmodule
